// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiplier job controller.
package mm_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [WORD_W-1:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_ACK,
    ST_WAIT_RESULT,
    ST_RELEASE,
    ST_DONE
  } mm_state_e;

  // Bit offset of element (r,c) in a row-major packed N x N word matrix.
  function automatic int unsigned elem_lo(input int unsigned r,
                                          input int unsigned c,
                                          input int unsigned n);
    return WORD_W * (r * n + c);
  endfunction

endpackage

// File: rtl/mm_index_counter.sv
// Row/column walker over an N x N result grid, row-major, with last-element flag.
module mm_index_counter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [IW-1:0] o_i,
  output logic [IW-1:0] o_j,
  output logic          o_last
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_clear) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_advance) begin
      if (r_j == LAST_IDX) begin
        r_j <= '0;
        r_i <= (r_i == LAST_IDX) ? '0 : r_i + 1'b1;
      end else begin
        r_j <= r_j + 1'b1;
      end
    end
  end

  assign o_i    = r_i;
  assign o_j    = r_j;
  assign o_last = (r_i == LAST_IDX) && (r_j == LAST_IDX);

endmodule

// File: rtl/matmul_operand_sequencer.sv
// Job controller feeding row/column operand pairs to one inner_product unit
// and assembling the returned scalars into the registered result matrix.
module matmul_operand_sequencer
  import mm_pkg::*;
#(
  parameter int unsigned N              = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_W*N*N-1:0] a_in,
  input  logic [WORD_W*N*N-1:0] b_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WORD_W*N*N-1:0] c_out,
  output logic [WORD_W*N-1:0]   ip_row,
  output logic [WORD_W*N-1:0]   ip_col,
  output logic                  ip_row_stb,
  output logic                  ip_col_stb,
  output logic                  ip_out_ack,
  input  logic                  ip_row_ack,
  input  logic                  ip_col_ack,
  input  logic [WORD_W-1:0]     ip_out,
  input  logic                  ip_out_stb
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  mm_state_e             r_state;
  logic [WORD_W*N*N-1:0] r_a;
  logic [WORD_W*N*N-1:0] r_b;
  logic [WORD_W*N*N-1:0] r_c;
  logic [WORD_W*N-1:0]   r_row;
  logic [WORD_W*N-1:0]   r_col;
  logic                  r_row_stb;
  logic                  r_col_stb;
  logic                  r_out_ack;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [TW-1:0]         r_tcnt;

  logic [IW-1:0]         w_i;
  logic [IW-1:0]         w_j;
  logic                  w_last;
  logic                  w_clear;
  logic                  w_advance;
  logic [WORD_W*N-1:0]   w_row;
  logic [WORD_W*N-1:0]   w_col;

  assign w_clear   = (r_state == ST_IDLE) && start;
  assign w_advance = (r_state == ST_RELEASE) && !ip_out_stb;

  mm_index_counter #(.N(N)) u_idx (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_i       (w_i),
    .o_j       (w_j),
    .o_last    (w_last)
  );

  // Row i of A and column j of B, gathered from the captured matrices.
  always_comb begin
    w_row = '0;
    w_col = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_row[WORD_W*k +: WORD_W] = r_a[elem_lo(32'(w_i), k, N) +: WORD_W];
      w_col[WORD_W*k +: WORD_W] = r_b[elem_lo(k, 32'(w_j), N) +: WORD_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_row_stb <= 1'b0;
      r_col_stb <= 1'b0;
      r_out_ack <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_tcnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a <= a_in;
            r_b <= b_in;
            for (int unsigned e = 0; e < N*N; e++) begin
              r_c[WORD_W*e +: WORD_W] <= FP_ZERO;
            end
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_row     <= w_row;
          r_col     <= w_col;
          r_row_stb <= 1'b1;
          r_col_stb <= 1'b1;
          r_out_ack <= 1'b1;
          r_state   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ip_row_ack && ip_col_ack) begin
            r_row_stb <= 1'b0;
            r_col_stb <= 1'b0;
            r_tcnt    <= '0;
            r_state   <= ST_WAIT_RESULT;
          end
        end
        ST_WAIT_RESULT: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (ip_out_stb) begin
            r_c[elem_lo(32'(w_i), 32'(w_j), N) +: WORD_W] <= ip_out;
            r_state <= ST_RELEASE;
          end else if ((TIMEOUT_CYCLES != 0) && (r_tcnt == TLAST)) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        // The unit keeps its out stb high if relaunched early, so hold here
        // until it drops before moving to the next element.
        ST_RELEASE: begin
          if (!ip_out_stb) begin
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_LAUNCH;
            end
          end
        end
        ST_DONE: begin
          r_busy    <= 1'b0;
          r_out_ack <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign c_out      = r_c;
  assign ip_row     = r_row;
  assign ip_col     = r_col;
  assign ip_row_stb = r_row_stb;
  assign ip_col_stb = r_col_stb;
  assign ip_out_ack = r_out_ack;

endmodule

// File: tb/tb_matmul_operand_sequencer.sv
// Directed bench for matmul_operand_sequencer with a behavioural inner_product.
module tb_matmul_operand_sequencer;
  import mm_pkg::*;

  localparam int NN = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [511:0] a_in, b_in;
  logic         busy, done, err;
  logic [511:0] c_out;
  logic [127:0] ip_row, ip_col;
  logic         ip_row_stb, ip_col_stb, ip_out_ack;
  logic         ip_row_ack, ip_col_ack;
  logic [31:0]  ip_out;
  logic         ip_out_stb;

  matmul_operand_sequencer #(.N(NN), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .err(err), .c_out(c_out),
    .ip_row(ip_row), .ip_col(ip_col), .ip_row_stb(ip_row_stb),
    .ip_col_stb(ip_col_stb), .ip_out_ack(ip_out_ack),
    .ip_row_ack(ip_row_ack), .ip_col_ack(ip_col_ack),
    .ip_out(ip_out), .ip_out_stb(ip_out_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int f2i(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'h00, 1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 31; b++) if (v[b]) e = b;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(e + 127), m[22:0]};
  endfunction

  // Behavioural inner_product plus protocol monitors, all on the falling edge.
  int mst, mcnt, mhold, hold_len, m_mode;
  int n_launch, n_results, proto_bad, relaunch_bad, unstable;
  int done_cnt, ncnt, ack_nedge, done_nedge;
  int log_idx[16];
  logic m_clear;
  logic [127:0] cap_row, cap_col, p_row, p_col;
  logic p_stb;

  initial begin
    ip_row_ack = 0; ip_col_ack = 0; ip_out_stb = 0; ip_out = '0;
    mst = 0; mcnt = 0; mhold = 0; ncnt = 0; done_cnt = 0;
    proto_bad = 0; relaunch_bad = 0; unstable = 0; p_stb = 0;
    ack_nedge = 0; done_nedge = 0;
    forever begin
      @(negedge clk);
      ncnt++;
      if (done) begin done_cnt++; done_nedge = ncnt; end
      if (ip_out_stb && (ip_row_stb || ip_col_stb)) relaunch_bad++;
      if (p_stb && (ip_row_stb || ip_col_stb) && (ip_row !== p_row || ip_col !== p_col)) unstable++;
      p_stb = ip_row_stb || ip_col_stb; p_row = ip_row; p_col = ip_col;
      if (!rst || m_clear) begin
        ip_row_ack = 0; ip_col_ack = 0; ip_out_stb = 0; mst = 0;
      end else begin
        case (mst)
          0: if (ip_row_stb && ip_col_stb) begin
               int pos;
               cap_row = ip_row; cap_col = ip_col; mcnt = 0; mst = 1;
               pos = 99;
               for (int k = 0; k < NN; k++) if (cap_row[32*k +: 32] == FP_ONE) pos = k;
               if (n_launch < 16) log_idx[n_launch] = pos * 4 + f2i(cap_col[31:0]);
               n_launch++;
             end
          1: begin
               mcnt++;
               if (!(ip_row_stb && ip_col_stb)) proto_bad++;
               if (mcnt == 1) ip_row_ack = 1;
               else begin ip_col_ack = 1; ack_nedge = ncnt; mst = 2; end
             end
          2: begin
               ip_row_ack = 0; ip_col_ack = 0;
               if (ip_row_stb || ip_col_stb) proto_bad++;
               mcnt = 1; mst = 3;
             end
          3: if (m_mode == 0) begin
               if (mcnt == 5) begin
                 int s;
                 s = 0;
                 for (int k = 0; k < NN; k++) s += f2i(cap_row[32*k +: 32]) * f2i(cap_col[32*k +: 32]);
                 ip_out = i2f(s); ip_out_stb = 1;
                 if (!ip_out_ack) proto_bad++;
                 mhold = 1; mst = 4; n_results++;
               end else mcnt++;
             end
          4: if (mhold >= hold_len) begin ip_out_stb = 0; mst = 0; end
             else mhold++;
          default: mst = 0;
        endcase
      end
    end
  end

  task automatic wait_done(input int budget, output bit seen);
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
  endtask

  task automatic pulse_start(input logic [511:0] a, input logic [511:0] b);
    @(negedge clk); #1;
    a_in = a; b_in = b; n_launch = 0; n_results = 0; start = 1;
    @(negedge clk); #1;
    start = 0; a_in = {16{32'hDEAD_BEEF}}; b_in = {16{32'hBAD0_F00D}};
  endtask

  task automatic clear_model();
    @(negedge clk); #1; m_clear = 1;
    @(negedge clk); #1; m_clear = 0;
  endtask

  logic [511:0] a_id, b_id, a_one, b_two, c_eight;
  bit seen;
  int d0, order_bad;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (got hang, expected finish)");
    $fatal(1);
  end

  initial begin
    rst = 0; start = 0; a_in = '0; b_in = '0; m_clear = 0;
    m_mode = 0; hold_len = 1; n_launch = 0; n_results = 0;
    a_id = '0; b_id = '0;
    for (int r = 0; r < NN; r++)
      for (int c = 0; c < NN; c++) begin
        if (r == c) a_id[32*(r*NN+c) +: 32] = FP_ONE;
        b_id[32*(r*NN+c) +: 32] = i2f(r*4 + c);
      end
    a_one = {16{32'h3F80_0000}};
    b_two = {16{32'h4000_0000}};
    c_eight = {16{32'h4100_0000}};

    repeat (2) @(negedge clk); #1;
    check("reset_ctl", {busy, done, err, ip_row_stb, ip_col_stb, ip_out_ack}, 0);
    check("reset_cout", c_out, 0);
    check("reset_ops", {ip_row, ip_col}, 0);
    @(negedge clk); rst = 1;

    // Identity x B, with a_in/b_in scrambled after accept.
    pulse_start(a_id, b_id);
    check("busy_after_accept", busy, 1);
    wait_done(2000, seen);
    check("id_done_seen", seen, 1);
    check("id_busy_in_done", busy, 1);
    check("id_cout", c_out, b_id);
    check("id_err", err, 0);
    check("id_results", n_results, 16);
    order_bad = 0;
    for (int n = 0; n < 16; n++) if (log_idx[n] != n) order_bad++;
    check("id_order", order_bad, 0);
    @(negedge clk); #1;
    check("id_after_done", {busy, done, ip_out_ack}, 0);
    check("id_done_cnt", done_cnt, 1);
    check("id_cout_hold", c_out, b_id);

    // Ones x 2.0
    pulse_start(a_one, b_two);
    wait_done(2000, seen);
    check("ones_done_seen", seen, 1);
    check("ones_cout", c_out, c_eight);
    check("ones_err", err, 0);

    // Out stb held 4 cycles
    hold_len = 4;
    pulse_start(a_id, b_id);
    wait_done(3000, seen);
    check("stuck_done_seen", seen, 1);
    check("stuck_cout", c_out, b_id);
    check("stuck_results", n_results, 16);
    check("stuck_no_relaunch", relaunch_bad, 0);
    hold_len = 1;

    // Timeout: unit never returns a result
    m_mode = 1;
    d0 = done_cnt;
    pulse_start(a_one, b_two);
    wait_done(500, seen);
    check("to_done_seen", seen, 1);
    check("to_err_with_done", err, 1);
    check("to_latency", done_nedge - ack_nedge, 17);
    check("to_cout_cleared", c_out, 0);
    @(negedge clk); #1;
    check("to_busy_drop", {busy, ip_out_ack}, 0);
    check("to_err_hold", err, 1);
    check("to_done_once", done_cnt - d0, 1);
    m_mode = 0;
    clear_model();
    pulse_start(a_one, b_two);
    check("to_err_cleared", err, 0);
    wait_done(2000, seen);
    check("to_next_cout", c_out, c_eight);

    // Reset during element (1,2)
    d0 = done_cnt;
    pulse_start(a_id, b_id);
    for (int c = 0; c < 2000 && n_launch < 7; c++) begin @(negedge clk); #1; end
    check("rst_reached_elem", n_launch, 7);
    rst = 0; #1;
    check("rst_mid_ctl", {busy, done, err, ip_row_stb, ip_col_stb, ip_out_ack}, 0);
    check("rst_mid_cout", c_out, 0);
    check("rst_mid_ops", {ip_row, ip_col}, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk); #1;
    check("rst_no_done", done_cnt - d0, 0);
    pulse_start(a_id, b_id);
    wait_done(2000, seen);
    check("rst_clean_cout", c_out, b_id);
    check("rst_clean_done", done_cnt - d0, 1);

    // Start pulses while busy and in the done cycle
    d0 = done_cnt;
    pulse_start(a_one, b_two);
    repeat (30) @(negedge clk);
    #1; a_in = a_id; b_in = b_id; start = 1;
    @(negedge clk); #1; start = 0;
    wait_done(2000, seen);
    check("sb_done_seen", seen, 1);
    start = 1; a_in = a_id; b_in = b_id;
    @(negedge clk); #1; start = 0;
    repeat (10) @(negedge clk); #1;
    check("sb_idle", busy, 0);
    check("sb_done_once", done_cnt - d0, 1);
    check("sb_cout", c_out, c_eight);

    check("proto_clean", proto_bad, 0);
    check("ops_stable", unstable, 0);
    check("no_relaunch", relaunch_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_operand_sequencer.md
Name: matmul_operand_sequencer

Overview:
- Job-level controller directly upstream of the inner_product stage in the matrix multiplier.
- Captures two N x N IEEE-754 single-precision matrices A and B on a start request.
- For each result element C[i][j], presents row i of A and column j of B to one inner_product instance using the stb/ack handshake, then collects the returned scalar.
- When all N*N elements are done, presents the complete C matrix with a done pulse.

Parameters:
- N, 4, matrix dimension; also the element count of the attached inner_product.
- TIMEOUT_CYCLES, 4096, maximum cycles spent waiting for any one ip result before the job aborts (0 = no timeout).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  job request, sampled only in IDLE.
- a_in  in  32*N*N  matrix A; element (r,c) at bits [32*(r*N+c) +: 32].
- b_in  in  32*N*N  matrix B, same layout.
- busy  out  1  high from job accept until the done cycle inclusive.
- done  out  1  one-cycle pulse at job end.
- err  out  1  set with done when the job aborted on timeout; cleared at next accept.
- c_out  out  32*N*N  result matrix, same layout; registered.
- ip_row  out  32*N  element k of row i at [32*k +: 32].
- ip_col  out  32*N  element k of column j, i.e. B[k][j], at [32*k +: 32].
- ip_row_stb  out  1  row operand valid.
- ip_col_stb  out  1  column operand valid.
- ip_out_ack  out  1  result-ready permission to inner_product.
- ip_row_ack  in  1  row accepted.
- ip_col_ack  in  1  column accepted.
- ip_out  in  32  inner product result.
- ip_out_stb  in  1  result valid.

Behaviour:
- Reset (async, rst=0): state IDLE; i=j=0; all outputs 0, including c_out, ip_row, ip_col and err. Reset mid-job aborts the job with no done pulse.
- Captured A/B registers are loaded only on accept. a_in and b_in are don't-care after the accept cycle.
- IDLE:
  - start=1 → capture a_in/b_in, clear c_out and err, set i=j=0, busy=1, go LAUNCH.
  - start is ignored in every other state.
- LAUNCH: drive ip_row/ip_col from captured A[i][*] and B[*][j]; assert ip_row_stb=ip_col_stb=ip_out_ack=1; go WAIT_ACK.
- WAIT_ACK:
  - Hold operands and stbs until ip_row_ack & ip_col_ack are both high in the same cycle.
  - Then drop both stbs next cycle, keep ip_out_ack=1, clear the timeout counter, go WAIT_RESULT.
  - An ack on only one side keeps waiting.
- WAIT_RESULT:
  - When ip_out_stb=1, write ip_out into c_out element (i,j) and go RELEASE.
  - The timeout counter increments each cycle. If TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES, set err=1 and go DONE.
- RELEASE:
  - Keep all stbs low; wait until ip_out_stb=0.
  - Mandatory: inner_product does not clear its out stb if relaunched while it is still high.
  - Then advance the indices: j+1; on j=N-1 wrap j=0 and i+1. If i=N-1 and j=N-1, go DONE, else go LAUNCH.
- DONE: done=1 for exactly one cycle; ip_out_ack=0, busy=0 next cycle; go IDLE. A start arriving in the DONE cycle is ignored; it must be held into IDLE.
- Latency: N*N ip transactions; overhead 3 cycles per element plus 2 per job.
- ip_row/ip_col are stable whenever either stb is high.
- c_out holds its value after done until the next accept.
- No arithmetic in this block; data is passed bit-exact.

Decomposition:
- Shared package mm_pkg: WORD_W=32; state encoding; FP constants FP_ZERO=32'h0, FP_ONE=32'h3F800000; element-offset helper function elem_lo(r,c,N).
- Natural sub-module: mm_index_counter (i/j counters with wrap and last flag), instantiated once.
- Everything else stays in the top-level FSM.

Test Plan:
- Use a behavioural ip model: acks 2 cycles after stb; result after 5 cycles; 1-cycle out stb, then a 1-cycle gap.
- Identity × B: A=I (FP_ONE diagonal), B elements = float(r*4+c). After 16 transactions done pulses once; c_out==b_in; err=0.
- Ones × 2.0s: A all 0x3F800000, B all 0x40000000, ip model sums. Every C element is 0x41000000 (8.0); ip transaction order is (0,0),(0,1)…(3,3).
- Stuck out stb: ip model holds ip_out_stb high 4 cycles. The sequencer captures once and raises no stb until out stb drops; C unchanged vs the reference model.
- Timeout: ip model never asserts ip_out_stb, TIMEOUT_CYCLES=16. done and err both pulse after the ack+16 cycles; busy drops; the next start clears err.
- Reset mid-job: rst low during element (1,2). All outputs 0 immediately with no done. After release, a start runs a full clean job.
- Start while busy: pulse start during a job, and in the DONE cycle. Each is ignored; exactly one done per accepted job.
